// File: rtl/skinny_sbox8_domd_pipelined.sv
// SKINNY-128 8-bit S-box, DOM-masked to order D (D+1 shares), fully pipelined.
// Each of the four S-box rounds is one pipeline stage that ends in one
// register bank. Each stage contains two DOM-indep AND gadgets for the
// masked NORs, plus a bank that carries the untouched share bits alongside.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: vi/ri. Output side: vo/ro. The pipe advances only
// when en = ~vo | ro, so a stall freezes every stage together. ri equals en,
// which makes the ro -> ri path combinational. so carries meaningful data
// only while vo is high.

// DOM-indep AND for one bit, with SH shares.
// Every product term is registered:
//   - the inner-domain term a_i&b_i
//   - the cross-domain terms a_i&b_j ^ z_ij
// Shares are compressed only after the register, so no net ever combines two
// shares of the same variable before the randomness has been applied.
module skinny_sbox8_dom_and #(
    parameter int SH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [SH-1:0]          a,
    input  logic [SH-1:0]          b,
    input  logic [SH*(SH-1)/2-1:0] z,
    output logic [SH-1:0]          q
);
    // term index i*SH+j holds a_i & b_j (masked by z when i != j)
    logic [SH*SH-1:0] term_d;
    logic [SH*SH-1:0] term_q;

    // Position of the random bit shared by the unordered pair (i, j), i < j
    function automatic int pair_idx(input int i, input int j);
        return i * (2 * SH - i - 1) / 2 + (j - i - 1);
    endfunction

    // Form inner and masked cross products; hold them when the pipe is stalled
    always_comb begin
        term_d = term_q;
        if (en) begin
            for (int i = 0; i < SH; i++) begin
                for (int j = 0; j < SH; j++) begin
                    if (i == j) begin
                        term_d[i*SH+j] = a[i] & b[i];
                    end else if (i < j) begin
                        term_d[i*SH+j] = (a[i] & b[j]) ^ z[pair_idx(i, j)];
                    end else begin
                        term_d[i*SH+j] = (a[i] & b[j]) ^ z[pair_idx(j, i)];
                    end
                end
            end
        end
    end

    // Product term register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            term_q <= '0;
        end else begin
            term_q <= term_d;
        end
    end

    // Compress the terms of domain i into output share i
    always_comb begin
        q = '0;
        for (int i = 0; i < SH; i++) begin
            for (int j = 0; j < SH; j++) begin
                q[i] = q[i] ^ term_q[i*SH+j];
            end
        end
    end
endmodule

// One S-box round: x4 ^= NOR(x7,x6), x0 ^= NOR(x3,x2), then the bit shuffle.
// Rounds 1-3 use the bit permutation; the last round only swaps bits 1 and 2.
// The shuffle is applied after the register, so y depends only on flops.
module skinny_sbox8_dom_stage #(
    parameter int SH   = 3,
    parameter bit LAST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [8*SH-1:0]       x,
    input  logic [SH*(SH-1)-1:0]  z,
    output logic [8*SH-1:0]       y
);
    localparam int NR = SH * (SH - 1) / 2;

    logic [SH-1:0]   a4;
    logic [SH-1:0]   b4;
    logic [SH-1:0]   a0;
    logic [SH-1:0]   b0;
    logic [SH-1:0]   q4;
    logic [SH-1:0]   q0;
    logic [8*SH-1:0] x_d;
    logic [8*SH-1:0] x_q;

    // Gather the NOR operands, inverting share 0 only so that ~a&~b = NOR(a,b)
    always_comb begin
        a4 = '0;
        b4 = '0;
        a0 = '0;
        b0 = '0;
        for (int s = 0; s < SH; s++) begin
            a4[s] = x[s*8+7];
            b4[s] = x[s*8+6];
            a0[s] = x[s*8+3];
            b0[s] = x[s*8+2];
        end
        a4[0] = ~x[7];
        b4[0] = ~x[6];
        a0[0] = ~x[3];
        b0[0] = ~x[2];
    end

    // Carry the share bytes alongside the gadget registers so all shares stay aligned
    always_comb begin
        x_d = x_q;
        if (en) begin
            x_d = x;
        end
    end

    // Share pass-through register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    (* keep_hierarchy = "yes" *)
    skinny_sbox8_dom_and #(.SH(SH)) u_and4 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a4),
        .b   (b4),
        .z   (z[NR-1:0]),
        .q   (q4)
    );

    (* keep_hierarchy = "yes" *)
    skinny_sbox8_dom_and #(.SH(SH)) u_and0 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a0),
        .b   (b0),
        .z   (z[2*NR-1:NR]),
        .q   (q0)
    );

    // Fold a gadget output into one share byte, then apply the round's bit shuffle
    function automatic logic [7:0] round_out(input logic [7:0] m_in, input logic q4b,
                                             input logic q0b);
        logic [7:0] m;
        m    = m_in;
        m[4] = m[4] ^ q4b;
        m[0] = m[0] ^ q0b;
        if (LAST) begin
            return {m[7:3], m[1], m[2], m[0]};
        end
        return {m[2], m[1], m[7], m[6], m[4], m[0], m[3], m[5]};
    endfunction

    // Per-share round output, built purely from registered values
    always_comb begin
        y = '0;
        for (int s = 0; s < SH; s++) begin
            y[s*8 +: 8] = round_out(x_q[s*8 +: 8], q4[s], q0[s]);
        end
    end
endmodule

// Top level: LANES independent masked S-boxes sharing one enable and one valid pipe.
// Lane l owns a 12*D*(D+1)-bit slice of r. Stage k takes its D*(D+1) bits
// from offset k*D*(D+1) of that slice; the upper part of the slice is reserved.
module skinny_sbox8_domd_pipelined #(
    parameter int D     = 2,
    parameter int LANES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*(D+1)*LANES-1:0]      si,
    input  logic [12*D*(D+1)*LANES-1:0]   r,
    input  logic                          vi,
    output logic                          ri,
    output logic [8*(D+1)*LANES-1:0]      so,
    output logic                          vo,
    input  logic                          ro
);
    localparam int SH = D + 1;
    localparam int SB = 8 * SH;         // share bits per lane
    localparam int RS = D * (D + 1);    // random bits per stage per lane
    localparam int RL = 12 * D * (D + 1); // random bits per lane

    logic       en;
    logic [3:0] v_d;
    logic [3:0] v_q;

    assign en = ~v_q[3] | ro;
    assign ri = en;
    assign vo = v_q[3];

    // Valid shift register tracks which stage holds a real item
    always_comb begin
        v_d = v_q;
        if (en) begin
            v_d = {v_q[2:0], vi};
        end
    end

    // Valid pipe register
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5*SB-1:0] chain;
        logic            r_spare_unused;

        assign chain[SB-1:0]      = si[l*SB +: SB];
        assign so[l*SB +: SB]     = chain[4*SB +: SB];
        assign r_spare_unused     = ^r[l*RL + 4*RS +: 8*RS];

        for (genvar k = 0; k < 4; k++) begin : g_stage
            skinny_sbox8_dom_stage #(
                .SH   (SH),
                .LAST (k == 3)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .x   (chain[k*SB +: SB]),
                .z   (r[l*RL + k*RS +: RS]),
                .y   (chain[(k+1)*SB +: SB])
            );
        end
    end
endmodule
